// File: rtl/segment_split_pkg.sv
// ----------------------------------------------------------------------------
// segment_split_pkg
// Shared definitions for the if/else segment splitter:
//   - state_e     : control FSM states (IDLE, RUN, FLUSH)
//   - SEG_DATA_W  : default segment word width
//   - SEG_DEPTH   : default per-branch FIFO depth
//   - SEG_CNT_W   : default statistics counter width
//   - clog2()     : pointer width helper for the branch FIFOs
// ----------------------------------------------------------------------------
package segment_split_pkg;

    localparam int unsigned SEG_DATA_W = 32;
    localparam int unsigned SEG_DEPTH  = 4;
    localparam int unsigned SEG_CNT_W  = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_e;

    // Smallest n with 2**n >= value. Depth is >= 2, so the result is never 0.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((64'd1 << result) < 64'(value)) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/if_else_segment_split_if.sv
// ----------------------------------------------------------------------------
// if_else_segment_split_if
// Bundles the combined segment input, both branch outputs and the statistics
// counters of the if/else segment splitter.
//   seg_valid/seg_ready/seg_data/seg_cond : combined input stream
//   if_valid/if_ready/if_data             : if-path output stream
//   else_valid/else_ready/else_data       : else-path output stream
//   if_count/else_count                   : words routed per branch
// Modports:
//   master : the environment (drives the input stream and branch readys)
//   slave  : the splitter itself
// ----------------------------------------------------------------------------
interface if_else_segment_split_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
);

    logic              seg_valid;
    logic              seg_ready;
    logic [DATA_W-1:0] seg_data;
    logic              seg_cond;

    logic              if_valid;
    logic              if_ready;
    logic [DATA_W-1:0] if_data;

    logic              else_valid;
    logic              else_ready;
    logic [DATA_W-1:0] else_data;

    logic [CNT_W-1:0]  if_count;
    logic [CNT_W-1:0]  else_count;

    modport master (
        output seg_valid, seg_data, seg_cond, if_ready, else_ready,
        input  seg_ready, if_valid, if_data, else_valid, else_data, if_count, else_count
    );

    modport slave (
        input  seg_valid, seg_data, seg_cond, if_ready, else_ready,
        output seg_ready, if_valid, if_data, else_valid, else_data, if_count, else_count
    );

endinterface

// File: rtl/segment_branch_fifo.sv
// ----------------------------------------------------------------------------
// segment_branch_fifo
// DEPTH x DATA_W synchronous FIFO for one branch of the segment splitter.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_clear        : discard all entries (wins over push/pop)
//   i_push         : write i_push_data (ignored when full)
//   i_push_data    : word to write
//   i_pop          : drop head entry (ignored when empty)
//   o_full         : occupancy == DEPTH
//   o_empty        : occupancy == 0
//   o_head         : head entry, valid while !o_empty
// No bypass: a pop from a full FIFO does not make room in the same cycle.
// ----------------------------------------------------------------------------
module segment_branch_fifo
    import segment_split_pkg::*;
#(
    parameter int unsigned DATA_W = SEG_DATA_W,
    parameter int unsigned DEPTH  = SEG_DEPTH
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_clear,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_push_data,
    input  logic              i_pop,
    output logic              o_full,
    output logic              o_empty,
    output logic [DATA_W-1:0] o_head
);

    localparam int unsigned PTR_W = clog2(DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;

    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);
    localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [OCC_W-1:0]  r_occ;

    logic w_push;
    logic w_pop;

    assign o_full  = (r_occ == OCC_FULL);
    assign o_empty = (r_occ == '0);
    assign o_head  = r_mem[r_rd_ptr];

    assign w_push = i_push && !o_full && !i_clear;
    assign w_pop  = i_pop && !o_empty && !i_clear;

    // Storage is reset so the head reads zero out of reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + OCC_ONE;
                2'b01:   r_occ <= r_occ - OCC_ONE;
                default: r_occ <= r_occ;
            endcase
        end
    end

endmodule

// File: rtl/if_else_segment_split.sv
// ----------------------------------------------------------------------------
// if_else_segment_split
// Splits a combined segment stream into an if-path and an else-path queue,
// chosen per word by seg_cond. Each path has its own FIFO and handshake.
// Ports:
//   clk    : clock, rising edge
//   reset  : asynchronous active-low reset
//   enable : 1 = accept traffic; 0 = drain queued words, accept nothing
//   flush  : single-cycle pulse, discards all queued words
//   bus    : if_else_segment_split_if.slave (input stream, both branch
//            streams, if_count / else_count)
// Build option:
//   SPLIT_STATS_EN : when defined, if_count / else_count count accepted
//                    words per branch (saturating, cleared only by reset);
//                    otherwise both are tied to zero.
// ----------------------------------------------------------------------------
module if_else_segment_split
    import segment_split_pkg::*;
#(
    parameter int unsigned DATA_W = SEG_DATA_W,
    parameter int unsigned DEPTH  = SEG_DEPTH,
    parameter int unsigned CNT_W  = SEG_CNT_W
) (
    input logic                    clk,
    input logic                    reset,
    input logic                    enable,
    input logic                    flush,
    if_else_segment_split_if.slave bus
);

    state_e r_state;
    state_e w_state_next;

    logic              w_if_full;
    logic              w_if_empty;
    logic [DATA_W-1:0] w_if_head;
    logic              w_else_full;
    logic              w_else_empty;
    logic [DATA_W-1:0] w_else_head;

    logic w_target_full;
    logic w_seg_ready;
    logic w_accept;
    logic w_if_push;
    logic w_else_push;
    logic w_if_valid;
    logic w_else_valid;
    logic w_if_pop;
    logic w_else_pop;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (flush) begin
            w_state_next = FLUSH;
        end else begin
            case (r_state)
                IDLE:    if (enable) w_state_next = RUN;
                RUN:     if (!enable) w_state_next = IDLE;
                FLUSH:   w_state_next = enable ? RUN : IDLE;
                default: w_state_next = IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Routing
    // ------------------------------------------------------------------
    // Ready is a function of the word's own branch, so it follows seg_cond
    // combinationally.
    assign w_target_full = bus.seg_cond ? w_if_full : w_else_full;
    assign w_seg_ready   = (r_state == RUN) && !w_target_full;

    // A word offered alongside flush is dropped rather than queued.
    assign w_accept    = bus.seg_valid && w_seg_ready && !flush;
    assign w_if_push   = w_accept && bus.seg_cond;
    assign w_else_push = w_accept && !bus.seg_cond;

    // Branch outputs drain in any state; the FIFOs are already empty in FLUSH.
    assign w_if_valid   = !w_if_empty && (r_state != FLUSH);
    assign w_else_valid = !w_else_empty && (r_state != FLUSH);

    assign w_if_pop   = w_if_valid && bus.if_ready && !flush;
    assign w_else_pop = w_else_valid && bus.else_ready && !flush;

    assign bus.seg_ready  = w_seg_ready;
    assign bus.if_valid   = w_if_valid;
    assign bus.if_data    = w_if_head;
    assign bus.else_valid = w_else_valid;
    assign bus.else_data  = w_else_head;

    // ------------------------------------------------------------------
    // Branch queues
    // ------------------------------------------------------------------
    segment_branch_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_if_fifo (
        .i_clk       (clk),
        .i_rst_n     (reset),
        .i_clear     (flush),
        .i_push      (w_if_push),
        .i_push_data (bus.seg_data),
        .i_pop       (w_if_pop),
        .o_full      (w_if_full),
        .o_empty     (w_if_empty),
        .o_head      (w_if_head)
    );

    segment_branch_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_else_fifo (
        .i_clk       (clk),
        .i_rst_n     (reset),
        .i_clear     (flush),
        .i_push      (w_else_push),
        .i_push_data (bus.seg_data),
        .i_pop       (w_else_pop),
        .o_full      (w_else_full),
        .o_empty     (w_else_empty),
        .o_head      (w_else_head)
    );

    // ------------------------------------------------------------------
    // Optional statistics
    // ------------------------------------------------------------------
`ifdef SPLIT_STATS_EN
    logic [CNT_W-1:0] r_if_count;
    logic [CNT_W-1:0] r_else_count;

    // Saturating counters; flush deliberately leaves them alone.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_if_count   <= '0;
            r_else_count <= '0;
        end else begin
            if (w_if_push && (r_if_count != {CNT_W{1'b1}})) begin
                r_if_count <= r_if_count + CNT_W'(1);
            end
            if (w_else_push && (r_else_count != {CNT_W{1'b1}})) begin
                r_else_count <= r_else_count + CNT_W'(1);
            end
        end
    end

    assign bus.if_count   = r_if_count;
    assign bus.else_count = r_else_count;
`else
    assign bus.if_count   = {CNT_W{1'b0}};
    assign bus.else_count = {CNT_W{1'b0}};
`endif

endmodule
